// File: rtl/ohc_pkg.sv
// Shared definitions for the one-hot modular ALU: opcode encodings and a
// constant ceil-log2 used to size binary residue fields.
package ohc_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ohc_encoder.sv
// One-hot to binary index conversion with an exactly-one-hot legality flag.
// The index is only meaningful when one_hot is set (it reads 0 for all-zero).
module ohc_encoder
  import ohc_pkg::*;
#(
  parameter  int M = 11,
  localparam int W = clog2(M)
) (
  input  logic [M-1:0] ohc,
  output logic [W-1:0] idx,
  output logic         one_hot
);

  logic any_s;
  logic multi_s;

  // OR-reduce indices of hot bits and flag a second hot bit
  always_comb begin
    any_s   = 1'b0;
    multi_s = 1'b0;
    idx     = '0;
    for (int k = 0; k < M; k++) begin
      multi_s = multi_s | (any_s & ohc[k]);
      any_s   = any_s | ohc[k];
      idx     = idx | ({W{ohc[k]}} & W'(k));
    end
    one_hot = any_s & ~multi_s;
  end

endmodule

// File: rtl/ohc_mod_alu.sv
// Modular arithmetic on one-hot residues: add/sub by rotation, an accumulator,
// and a two-stage valid/ready pipeline with binary conversion in the last stage.
module ohc_mod_alu
  import ohc_pkg::*;
#(
  parameter  int M = 11,
  localparam int W = clog2(M)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_ohc,
  output logic [W-1:0] out_bin,
  output logic         out_err
);

  // Rotation amounts are residues, always below M, so the complementary
  // shift never goes negative and a zero amount leaves x unchanged.
  function automatic logic [M-1:0] rotl(input logic [M-1:0] x, input logic [W-1:0] n);
    return (x << n) | (x >> (M - int'(n)));
  endfunction

  function automatic logic [M-1:0] rotr(input logic [M-1:0] x, input logic [W-1:0] n);
    return (x >> n) | (x << (M - int'(n)));
  endfunction

  logic [W-1:0] a_idx_s, b_idx_s, s1_idx_s;
  logic         a_ok_s, b_ok_s, s1_ok_s;
  logic [M-1:0] acc_r;
  logic [M-1:0] raw_s, res_s;
  logic         err_s;
  logic         s1_valid_r, s1_err_r;
  logic [M-1:0] s1_ohc_r;
  logic         s2_adv_s, accept_s, acc_wr_s;

  ohc_encoder #(.M(M)) u_enc_a  (.ohc(a),        .idx(a_idx_s),  .one_hot(a_ok_s));
  ohc_encoder #(.M(M)) u_enc_b  (.ohc(b),        .idx(b_idx_s),  .one_hot(b_ok_s));
  ohc_encoder #(.M(M)) u_enc_s2 (.ohc(s1_ohc_r), .idx(s1_idx_s), .one_hot(s1_ok_s));

  // Ready depends only on stage occupancy and out_ready, never on in_valid
  assign s2_adv_s = !out_valid || out_ready;
  assign in_ready = !s1_valid_r || s2_adv_s;
  assign accept_s = in_valid && in_ready;
  assign acc_wr_s = accept_s && !err_s && ((op == OP_ACC) || (op == OP_LOAD));

  // Operation select and legality; an illegal request yields a zero residue
  always_comb begin
    raw_s = '0;
    err_s = 1'b0;
    case (op)
      OP_ADD: begin
        raw_s = rotl(a, b_idx_s);
        err_s = !a_ok_s || !b_ok_s;
      end
      OP_SUB: begin
        raw_s = rotr(a, b_idx_s);
        err_s = !a_ok_s || !b_ok_s;
      end
      OP_ACC: begin
        raw_s = rotl(acc_r, a_idx_s);
        err_s = !a_ok_s;
      end
      OP_LOAD: begin
        raw_s = a;
        err_s = !a_ok_s;
      end
      default: begin
        raw_s = '0;
        err_s = 1'b1;
      end
    endcase
    res_s = err_s ? '0 : raw_s;
  end

  // Accumulator updates at the input handshake so ACC requests chain freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {{(M-1){1'b0}}, 1'b1};
    end else if (acc_wr_s) begin
      acc_r <= res_s;
    end
  end

  // Stage 1: one-hot result and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_ohc_r   <= '0;
      s1_err_r   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_ohc_r <= res_s;
        s1_err_r <= err_s;
      end
    end
  end

  // Stage 2: registered outputs, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ohc   <= '0;
      out_bin   <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_ohc <= s1_ohc_r;
        out_bin <= s1_ok_s ? s1_idx_s : '0;
        out_err <= s1_err_r;
      end
    end
  end

endmodule

// File: tb/tb_ohc_mod_alu.sv
// Directed bench for ohc_mod_alu at M=11 with hand-computed residues.
module tb_ohc_mod_alu;
  import ohc_pkg::*;

  localparam int M = 11;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] out_ohc;
  logic [W-1:0] out_bin;
  logic         out_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ohc_mod_alu #(.M(M)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_ohc(out_ohc), .out_bin(out_bin), .out_err(out_err)
  );

  function automatic logic [M-1:0] oh(input int k);
    logic [M-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = OP_ADD; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, out_err, out_ohc, out_bin} !== {1'b0, 1'b0, 11'h000, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b e=%b ohc=%h bin=%0d, expected all zero",
               out_valid, out_err, out_ohc, out_bin);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    in_valid = 1'b1; op = OP_ADD; a = oh(7); b = oh(6);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_latency: out_valid got %b expected 0 one cycle after accept", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_err, out_ohc, out_bin} !== {1'b1, 1'b0, 11'h004, 4'd2}) begin
      n_fail++;
      $display("FAIL add_7_6: got v=%b e=%b ohc=%h bin=%0d expected v=1 e=0 ohc=004 bin=2",
               out_valid, out_err, out_ohc, out_bin);
    end
  endtask

  task automatic test_sub();
    logic [1:0]     t_op[4];
    logic [M-1:0]   t_a[4];
    logic [M-1:0]   t_b[4];
    logic [M+W:0]   t_exp[4];
    t_op[0] = OP_SUB; t_a[0] = oh(3);  t_b[0] = oh(5);  t_exp[0] = {1'b0, 11'h200, 4'd9};
    t_op[1] = OP_SUB; t_a[1] = oh(0);  t_b[1] = oh(0);  t_exp[1] = {1'b0, 11'h001, 4'd0};
    t_op[2] = OP_ADD; t_a[2] = oh(10); t_b[2] = oh(10); t_exp[2] = {1'b0, 11'h200, 4'd9};
    t_op[3] = OP_SUB; t_a[3] = oh(2);  t_b[3] = oh(9);  t_exp[3] = {1'b0, 11'h010, 4'd4};
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        n_checks++;
        if ({out_valid, out_err, out_ohc, out_bin} !== {1'b1, t_exp[j-2]}) begin
          n_fail++;
          $display("FAIL sub_vec%0d: got v=%b e=%b ohc=%h bin=%0d expected {err,ohc,bin}=%h",
                   j - 2, out_valid, out_err, out_ohc, out_bin, t_exp[j-2]);
        end
      end
      if (j < 4) begin
        in_valid = 1'b1; op = t_op[j]; a = t_a[j]; b = t_b[j];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   t_op[4];
    logic [M-1:0] t_a[4];
    logic [M+W:0] t_exp[4];
    t_op[0] = OP_LOAD; t_a[0] = oh(0); t_exp[0] = {1'b0, 11'h001, 4'd0};
    t_op[1] = OP_ACC;  t_a[1] = oh(4); t_exp[1] = {1'b0, 11'h010, 4'd4};
    t_op[2] = OP_ACC;  t_a[2] = oh(4); t_exp[2] = {1'b0, 11'h100, 4'd8};
    t_op[3] = OP_ACC;  t_a[3] = oh(4); t_exp[3] = {1'b0, 11'h002, 4'd1};
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        n_checks++;
        if ({out_valid, out_err, out_ohc, out_bin} !== {1'b1, t_exp[j-2]}) begin
          n_fail++;
          $display("FAIL acc_chain%0d: got v=%b e=%b ohc=%h bin=%0d expected {err,ohc,bin}=%h",
                   j - 2, out_valid, out_err, out_ohc, out_bin, t_exp[j-2]);
        end
      end
      if (j < 4) begin
        in_valid = 1'b1; op = t_op[j]; a = t_a[j]; b = 11'h7FF;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  // Accumulator holds residue 1 on entry (left by the ACC chain)
  task automatic test_illegal();
    logic [1:0]   t_op[5];
    logic [M-1:0] t_a[5];
    logic [M-1:0] t_b[5];
    logic [M+W:0] t_exp[5];
    t_op[0] = OP_ADD; t_a[0] = 11'h003; t_b[0] = oh(1);   t_exp[0] = {1'b1, 11'h000, 4'd0};
    t_op[1] = OP_ACC; t_a[1] = 11'h000; t_b[1] = oh(1);   t_exp[1] = {1'b1, 11'h000, 4'd0};
    t_op[2] = OP_ACC; t_a[2] = oh(1);   t_b[2] = 11'h000; t_exp[2] = {1'b0, 11'h004, 4'd2};
    t_op[3] = OP_SUB; t_a[3] = oh(1);   t_b[3] = 11'h0C0; t_exp[3] = {1'b1, 11'h000, 4'd0};
    t_op[4] = OP_ACC; t_a[4] = oh(2);   t_b[4] = 11'h7FF; t_exp[4] = {1'b0, 11'h010, 4'd4};
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j >= 2) begin
        n_checks++;
        if ({out_valid, out_err, out_ohc, out_bin} !== {1'b1, t_exp[j-2]}) begin
          n_fail++;
          $display("FAIL illegal%0d: got v=%b e=%b ohc=%h bin=%0d expected {err,ohc,bin}=%h",
                   j - 2, out_valid, out_err, out_ohc, out_bin, t_exp[j-2]);
        end
      end
      if (j < 5) begin
        in_valid = 1'b1; op = t_op[j]; a = t_a[j]; b = t_b[j];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [M-1:0] t_a[3];
    logic [M-1:0] t_b[3];
    int accepts;
    t_a[0] = oh(1); t_b[0] = oh(1);
    t_a[1] = oh(2); t_b[1] = oh(3);
    t_a[2] = oh(4); t_b[2] = oh(5);
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD;
      a = t_a[accepts]; b = t_b[accepts];
      #1;
      if (i >= 2) begin
        n_checks++;
        if ({out_valid, out_err, out_ohc, out_bin} !== {1'b1, 1'b0, 11'h004, 4'd2}) begin
          n_fail++;
          $display("FAIL stall_hold%0d: got v=%b e=%b ohc=%h bin=%0d expected v=1 ohc=004 bin=2",
                   i, out_valid, out_err, out_ohc, out_bin);
        end
      end
      if (in_ready) accepts++;
    end
    n_checks++;
    if (accepts !== 2) begin
      n_fail++;
      $display("FAIL stall_accepts: got %0d expected 2", accepts);
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_in_ready: got %b expected 0", in_ready);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = OP_ADD; a = t_a[2]; b = t_b[2];
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_shift_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_ohc, out_bin} !== {1'b1, 11'h020, 4'd5}) begin
      n_fail++;
      $display("FAIL release_2nd: got v=%b ohc=%h bin=%0d expected v=1 ohc=020 bin=5",
               out_valid, out_ohc, out_bin);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_ohc, out_bin} !== {1'b1, 11'h200, 4'd9}) begin
      n_fail++;
      $display("FAIL release_3rd: got v=%b ohc=%h bin=%0d expected v=1 ohc=200 bin=9",
               out_valid, out_ohc, out_bin);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL release_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ACC; a = oh(5); b = '0;
    @(negedge clk);
    a = oh(6);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_precond: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_err, out_ohc, out_bin} !== {1'b0, 1'b0, 11'h000, 4'd0}) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b e=%b ohc=%h bin=%0d expected all zero",
               out_valid, out_err, out_ohc, out_bin);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; op = OP_ACC; a = oh(3); b = '0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_stale: out_valid got %b expected 0", out_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_err, out_ohc, out_bin} !== {1'b1, 1'b0, 11'h008, 4'd3}) begin
      n_fail++;
      $display("FAIL midrst_acc3: got v=%b e=%b ohc=%h bin=%0d expected v=1 ohc=008 bin=3",
               out_valid, out_err, out_ohc, out_bin);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_dup: out_valid got %b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
